// File: rtl/simple_proc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : simple_proc_pkg                                             |
// | Brief  : Shared word width, opcode fields, fetch states and error    |
// |          codes for the simple processor and its instruction feeder. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package simple_proc_pkg;

   // Processor data/instruction word width
   localparam int DW = 9;

   // Opcode field values found in DIN[8:6]
   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_MVI = 3'b011;

   // Fetch sequencer states
   typedef enum logic [2:0] {
      FS_IDLE  = 3'd0,
      FS_ISSUE = 3'd1,
      FS_HOLD  = 3'd2,
      FS_WAIT  = 3'd3,
      FS_HALT  = 3'd4,
      FS_ERR   = 3'd5
   } fetch_state_e;

   // Error codes reported on err
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_TRUNC   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/prog_rom_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : prog_rom_ram                                                |
// | Brief  : Program store, 2**AW x DW, one synchronous write port and   |
// |          two combinational read ports (instruction and immediate).  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module prog_rom_ram #(
   parameter int AW = 5,
   parameter int DW = 9
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_a_i,
   output logic [DW-1:0] rdata_a_o,
   input  logic [AW-1:0] raddr_b_i,
   output logic [DW-1:0] rdata_b_o
);

   // Contents are deliberately not reset so a program survives Resetn
   logic [DW-1:0] mem_q [2**AW];

   // Single write port; the caller gates we_i while a program runs
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Combinational reads so ISSUE/HOLD see the word in the same cycle
   assign rdata_a_o = mem_q[raddr_a_i];
   assign rdata_b_o = mem_q[raddr_b_i];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : instr_fetch_sequencer                                       |
// | Brief  : Walks a program counter through a local program memory and  |
// |          issues instruction (and mvi immediate) words to the         |
// |          processor, waiting for Done with a timeout.                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module instr_fetch_sequencer #(
   parameter int         AW      = 5,
   parameter int         DW      = simple_proc_pkg::DW,
   parameter logic [2:0] MVI_OP  = simple_proc_pkg::OP_MVI,
   parameter int         TIMEOUT = 15
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [DW-1:0] prog_data,
   input  logic [AW:0]   prog_len,
   input  logic          start,
   input  logic          Done,
   output logic [DW-1:0] DIN,
   output logic          Run,
   output logic [AW:0]   pc,
   output logic          busy,
   output logic          halted,
   output logic [1:0]    err
);

   import simple_proc_pkg::*;

   // Timer counts cycles since the ISSUE cycle; it never exceeds TIMEOUT+2
   localparam int TW = $clog2(TIMEOUT + 3);

   fetch_state_e  state_q, state_d;
   logic [AW:0]   pc_q, pc_d;
   logic [AW:0]   len_q, len_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    err_q, err_d;

   logic [AW-1:0] cur_addr;
   logic [AW-1:0] imm_addr;
   logic [DW-1:0] cur_word;
   logic [DW-1:0] imm_word;
   logic          cur_is_mvi;
   logic          last_word;
   logic [AW:0]   pc_step;
   logic          busy_w;

   assign busy_w     = (state_q == FS_ISSUE) || (state_q == FS_HOLD) || (state_q == FS_WAIT);
   assign cur_addr   = pc_q[AW-1:0];
   assign imm_addr   = cur_addr + AW'(1);
   assign cur_is_mvi = (cur_word[DW-1 -: 3] == MVI_OP);
   assign last_word  = (pc_q == (len_q - (AW+1)'(1)));
   assign pc_step    = pc_q + (cur_is_mvi ? (AW+1)'(2) : (AW+1)'(1));

   prog_rom_ram #(
      .AW (AW),
      .DW (DW)
   ) u_mem (
      .clk_i     (Clock),
      .we_i      (prog_we && !busy_w),
      .waddr_i   (prog_addr),
      .wdata_i   (prog_data),
      .raddr_a_i (cur_addr),
      .rdata_a_o (cur_word),
      .raddr_b_i (imm_addr),
      .rdata_b_o (imm_word)
   );

   // State, program counter, latched length, timer and error code
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= FS_IDLE;
         pc_q    <= '0;
         len_q   <= '0;
         timer_q <= '0;
         err_q   <= ERR_NONE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         len_q   <= len_d;
         timer_q <= timer_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic and the word/pulse presented to the processor
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      len_d   = len_q;
      err_d   = err_q;
      timer_d = '0;
      DIN     = '0;
      Run     = 1'b0;
      unique case (state_q)
         FS_IDLE, FS_HALT, FS_ERR: begin
            if (start) begin
               len_d   = prog_len;
               pc_d    = '0;
               err_d   = ERR_NONE;
               state_d = (prog_len == '0) ? FS_HALT : FS_ISSUE;
            end
         end
         FS_ISSUE: begin
            DIN     = cur_word;
            timer_d = timer_q + TW'(1);
            // An mvi in the final slot has no immediate word to send
            if (cur_is_mvi && last_word) begin
               err_d   = ERR_TRUNC;
               state_d = FS_ERR;
            end else begin
               Run     = 1'b1;
               state_d = FS_HOLD;
            end
         end
         FS_HOLD: begin
            DIN     = cur_is_mvi ? imm_word : cur_word;
            timer_d = timer_q + TW'(1);
            state_d = FS_WAIT;
         end
         FS_WAIT: begin
            DIN     = cur_is_mvi ? imm_word : cur_word;
            timer_d = timer_q + TW'(1);
            // Done takes priority over an expiring timer in the same cycle
            if (Done) begin
               pc_d    = pc_step;
               timer_d = '0;
               state_d = (pc_step >= len_q) ? FS_HALT : FS_ISSUE;
            end else if (timer_q >= TW'(TIMEOUT)) begin
               err_d   = ERR_TIMEOUT;
               state_d = FS_ERR;
            end
         end
         default: begin
            state_d = FS_IDLE;
         end
      endcase
   end

   assign pc     = pc_q;
   assign busy   = busy_w;
   assign halted = (state_q == FS_HALT);
   assign err    = err_q;

endmodule
`default_nettype wire

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Upstream feeder for simple_processor_Top.
- Holds a small program memory that the bench or loader writes.
- On start, it walks a program counter through the memory and presents each instruction word on DIN with a one-cycle Run pulse.
- For mvi, it then presents the immediate word. It waits for the processor's Done before issuing the next instruction, and flags a timeout if Done never arrives.

Parameters:
AW, 5, program memory address width (2**AW words)
DW, 9, instruction/data word width (matches processor DIN)
MVI_OP, 3'b011, value of DIN[8:6] identifying a two-word mvi instruction
TIMEOUT, 15, max cycles waited for Done after issue before error

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
prog_we  input  1  program memory write strobe (accepted only when not busy)
prog_addr  input  AW  program memory write address
prog_data  input  DW  program memory write data
prog_len  input  AW+1  number of words in program (0..2**AW), sampled on start
start  input  1  begin execution from address 0 (accepted only when not busy)
Done  input  1  processor instruction-complete strobe
DIN  output  DW  word presented to processor
Run  output  1  one-cycle issue pulse to processor
pc  output  AW+1  address of current or next instruction
busy  output  1  high from accepted start until HALT/ERR
halted  output  1  program completed normally
err  output  2  00 none, 01 Done timeout, 10 truncated mvi (mvi at last word)

Behaviour:
- Reset (async, Resetn=0):
  - DIN=0, Run=0, pc=0, busy=0, halted=0, err=00, state=IDLE, timer=0.
  - Memory contents are not reset.
- States: IDLE, ISSUE, HOLD, WAIT, HALT, ERR.
- Memory write: one synchronous write port; writes when prog_we=1 && busy=0. prog_we while busy is ignored.
- IDLE/HALT/ERR + start=1:
  - Latch len=prog_len, pc=0, clear halted/err, busy=1.
  - If len==0: go to HALT with halted=1, busy=0 next cycle.
  - Otherwise go to ISSUE.
- ISSUE (one cycle):
  - DIN=mem[pc], Run=1, timer=0.
  - If mem[pc][8:6]==MVI_OP and pc==len-1: err=10, Run forced 0, go to ERR.
  - Otherwise go to HOLD.
- HOLD: Run=0.
  - If the instruction is mvi, DIN=mem[pc+1] (immediate); otherwise DIN keeps the instruction word.
  - Go to WAIT.
- WAIT: DIN held as in HOLD, Run=0, timer increments each cycle.
  - Done=1: pc += 2 for mvi, 1 otherwise. If new pc >= len go to HALT (halted=1, busy=0); else go to ISSUE.
  - timer==TIMEOUT with no Done: err=01, busy=0, go to ERR.
- Instruction spacing: minimum issue-to-issue spacing is 3 cycles (ISSUE, HOLD, WAIT with Done).
- Done outside WAIT (including HOLD and the ISSUE cycle) is ignored.
- Done and timer==TIMEOUT in the same cycle: Done wins.
- HALT/ERR: DIN=0, Run=0. pc holds its final value.
- start while busy: ignored.
- Reset mid-program: immediately returns to IDLE, outputs go to reset values, memory is retained, and a fresh start reruns from 0.
- Widths: pc is AW+1 bits so len=2**AW is reachable. pc+1 addressing never exceeds len-1, guaranteed by the truncated-mvi check.

Decomposition:
- Shared package simple_proc_pkg:
  - DW, the opcode field localparams (OP_MV, OP_MVI=MVI_OP, OP_ADD, OP_SUB).
  - The fetch state enum.
  - err code constants.
- One sub-module: prog_rom_ram (2**AW x DW, one synchronous write port, combinational read). Combinational read keeps the ISSUE/HOLD timing above exact.
- The FSM, pc and timer live in instr_fetch_sequencer.

Test Plan:
- Reset: hold Resetn=0 with start=1 and Done toggling -> DIN=0, Run=0, pc=0, busy=0, err=00 throughout.
- Single mvi:
  - Stimulus: load mem[0]=9'b011000001, mem[1]=9'b111001111, prog_len=2, start, Done=1 three cycles after Run.
  - Expected: Run pulse with DIN=011000001, then DIN=111001111 until Done; then pc=2, halted=1, busy=0.
- Mixed program:
  - Stimulus: mvi R2 (9'b011010001, imm 9'b111111111), then a one-word instruction 9'b000001010; prog_len=3; Done returned 2 cycles after each Run.
  - Expected: exactly two Run pulses, pc sequence 0->2->3, halted=1.
- Timeout: prog_len=1, mem[0]=9'b000001010, Done never asserted -> err=01 exactly TIMEOUT cycles after HOLD, busy=0, pc=0.
- Truncated mvi: prog_len=1, mem[0]=9'b011000001, start -> no Run pulse, err=10, busy=0.
- Corner cases:
  - prog_len=0 + start -> halted=1 within 2 cycles, no Run.
  - Resetn pulsed low during WAIT -> IDLE.
  - Restart: start again -> program reruns from pc=0, memory intact.
  - prog_we during busy -> memory unchanged.
